// File: rtl/uart_os_receiver.sv
// Oversampling receiver for 7-bit + parity frames with parity and stop-bit checking.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority voting on each data/parity/stop bit.
module uart_os_receiver #(
    parameter logic        START_SIG  = 1'b1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in,
    output logic       received,
    output logic [6:0] received_data,
    output logic       check_receive_parity,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [6:0]    shreg;
    logic          par;
    logic          pending;
    logic          sync1;
    logic          line_s;
    logic          bit_val;
    logic          at_centre;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= ~START_SIG;
            line_s <= ~START_SIG;
        end else begin
            sync1  <= s_in;
            line_s <= sync1;
        end
    end

    assign at_centre = (cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] CNT_M3 = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] CNT_M2 = CW'(OVERSAMPLE - 2);
    logic s_a;
    logic s_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_a <= 1'b0;
            s_b <= 1'b0;
        end else begin
            if (cnt == CNT_M3) s_a <= line_s;
            if (cnt == CNT_M2) s_b <= line_s;
        end
    end

    always_comb begin
        bit_val = (s_a & s_b) | (s_a & line_s) | (s_b & line_s);
    end
`else
    always_comb begin
        bit_val = line_s;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            bit_idx              <= '0;
            shreg                <= '0;
            par                  <= 1'b0;
            pending              <= 1'b0;
            received             <= 1'b0;
            received_data        <= '0;
            check_receive_parity <= 1'b0;
            frame_error          <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            // Results are latched at the stop-bit centre; the strobe follows one cycle later.
            received <= pending;
            pending  <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_s == START_SIG) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (line_s == START_SIG) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    cnt <= at_centre ? '0 : cnt + 1'b1;
                    if (at_centre) begin
                        shreg <= {bit_val, shreg[6:1]};
                        if (bit_idx == 3'd6) state <= PARITY;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: begin
                    cnt <= at_centre ? '0 : cnt + 1'b1;
                    if (at_centre) begin
                        par   <= bit_val;
                        state <= STOP;
                    end
                end
                STOP: begin
                    cnt <= at_centre ? '0 : cnt + 1'b1;
                    if (at_centre) begin
                        pending              <= 1'b1;
                        received_data        <= shreg;
                        check_receive_parity <= ((^{shreg, par}) == PARITY_ODD);
                        frame_error          <= (bit_val != ~START_SIG);
                        if (bit_val == ~START_SIG) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (line_s == ~START_SIG) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_os_receiver.sv
// Self-checking bench for uart_os_receiver: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_uart_os_receiver;

    localparam int   OS         = 16;
    localparam logic START_SIG  = 1'b1;
    localparam bit   PARITY_ODD = 1'b0;
    localparam int   LAT        = 2 + OS / 2 + 9 * OS + 1;

    logic       clk;
    logic       rst;
    logic       s_in;
    logic       received;
    logic [6:0] received_data;
    logic       check_receive_parity;
    logic       frame_error;
    logic       busy;

    uart_os_receiver #(
        .START_SIG  (START_SIG),
        .OVERSAMPLE (OS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_in                 (s_in),
        .received             (received),
        .received_data        (received_data),
        .check_receive_parity (check_receive_parity),
        .frame_error          (frame_error),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int         q_cyc[$];
    logic [6:0] q_data[$];
    logic       q_par[$];
    logic       q_fe[$];

    always @(negedge clk) begin
        if (received === 1'b1) begin
            q_cyc.push_back(cyc);
            q_data.push_back(received_data);
            q_par.push_back(check_receive_parity);
            q_fe.push_back(frame_error);
        end
    end

    logic [6:0] last_d;
    logic       last_par;
    logic       last_fe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic good_parity_bit(input logic [6:0] d);
        return logic'(($countones(d) % 2) != 0) ^ PARITY_ODD;
    endfunction

    function automatic logic model_par_ok(input logic [6:0] d, input logic p);
        return (($countones({p, d}) % 2) == int'(PARITY_ODD));
    endfunction

    function automatic logic model_fe(input logic stop);
        return (stop !== ~START_SIG);
    endfunction

    task automatic clear_q();
        q_cyc.delete();
        q_data.delete();
        q_par.delete();
        q_fe.delete();
    endtask

    // Drives one full 10-bit frame; glitch >= 0 inverts the line for that one oversample cycle.
    task automatic send_frame(input logic [6:0] d, input logic p, input logic stop,
                              input int glitch, output int t0);
        logic [9:0] f;
        f  = {stop, p, d, START_SIG};
        t0 = cyc;
        for (int c = 0; c < 10 * OS; c++) begin
            s_in = (c == glitch) ? ~f[c / OS] : f[c / OS];
            tick(1);
        end
    endtask

    task automatic expect_one(input string tag, input int t0, input logic [6:0] d,
                              input logic p, input logic stop);
        check({tag, "_count"}, q_cyc.size(), 1);
        if (q_cyc.size() > 0) begin
            check({tag, "_time"}, q_cyc[0], t0 + 1 + LAT);
            check({tag, "_data"}, q_data[0], d);
            check({tag, "_par"},  q_par[0], model_par_ok(d, p));
            check({tag, "_fe"},   q_fe[0], model_fe(stop));
        end
        last_d   = d;
        last_par = model_par_ok(d, p);
        last_fe  = model_fe(stop);
        clear_q();
    endtask

    initial begin
        int t0;
        int t1;
        logic [6:0] d;
        logic p;
        logic [9:0] f;

        rst  = 1'b1;
        s_in = ~START_SIG;
        tick(4);
        check("rst_received", received, 0);
        check("rst_data", received_data, 0);
        check("rst_par", check_receive_parity, 0);
        check("rst_fe", frame_error, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(20);
        clear_q();

        // Good frame, latency check
        send_frame(7'h55, good_parity_bit(7'h55), ~START_SIG, -1, t0);
        tick(8);
        expect_one("t1", t0, 7'h55, good_parity_bit(7'h55), ~START_SIG);
        check("t1_busy_after", busy, 0);
        tick(10);

        // Inverted parity
        send_frame(7'h2A, ~good_parity_bit(7'h2A), ~START_SIG, -1, t0);
        tick(8);
        expect_one("t2", t0, 7'h2A, ~good_parity_bit(7'h2A), ~START_SIG);
        tick(10);

        // Bad stop bit, then a stuck line for 40 bits
        send_frame(7'h7F, good_parity_bit(7'h7F), START_SIG, -1, t0);
        for (int i = 0; i < 4; i++) begin
            tick(10 * OS);
            check("t3_busy_stuck", busy, 1);
        end
        expect_one("t3", t0, 7'h7F, good_parity_bit(7'h7F), START_SIG);
        s_in = ~START_SIG;
        tick(6);
        check("t3_busy_released", busy, 0);
        tick(10);

        // Short start glitch on an idle line
        s_in = START_SIG;
        tick(4);
        s_in = ~START_SIG;
        tick(200);
        check("t4_no_strobe", q_cyc.size(), 0);
        check("t4_busy", busy, 0);
        check("t4_data_held", received_data, last_d);
        check("t4_par_held", check_receive_parity, last_par);
        check("t4_fe_held", frame_error, last_fe);
        clear_q();

        // Back-to-back frames with one stop bit
        send_frame(7'h01, good_parity_bit(7'h01), ~START_SIG, -1, t0);
        send_frame(7'h40, good_parity_bit(7'h40), ~START_SIG, -1, t1);
        tick(8);
        check("t5_count", q_cyc.size(), 2);
        if (q_cyc.size() == 2) begin
            check("t5_spacing", q_cyc[1] - q_cyc[0], 10 * OS);
            check("t5_time0", q_cyc[0], t0 + 1 + LAT);
            check("t5_data0", q_data[0], 7'h01);
            check("t5_data1", q_data[1], 7'h40);
            check("t5_par0", q_par[0], 1);
            check("t5_par1", q_par[1], 1);
            check("t5_fe1", q_fe[1], 0);
        end
        clear_q();
        tick(10);

        // Reset during bit 3 abandons the frame
        f = {~START_SIG, good_parity_bit(7'h7F), 7'h7F, START_SIG};
        for (int c = 0; c < 4 * OS + 8; c++) begin
            s_in = f[c / OS];
            tick(1);
        end
        rst = 1'b1;
        tick(1);
        rst  = 1'b0;
        s_in = ~START_SIG;
        tick(20 * OS);
        check("t6_no_strobe", q_cyc.size(), 0);
        check("t6_data_rst", received_data, 0);
        check("t6_par_rst", check_receive_parity, 0);
        check("t6_busy", busy, 0);
        clear_q();
        send_frame(7'h33, good_parity_bit(7'h33), ~START_SIG, -1, t0);
        tick(8);
        expect_one("t6", t0, 7'h33, good_parity_bit(7'h33), ~START_SIG);
        tick(10);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inversion at the centre of data bit 2
        send_frame(7'h55, good_parity_bit(7'h55), ~START_SIG, 3 * OS + OS / 2, t0);
        tick(8);
        expect_one("t7_majority", t0, 7'h55, good_parity_bit(7'h55), ~START_SIG);
        tick(10);
`endif

        // Random frames with random parity errors and idle gaps
        for (int i = 0; i < 8; i++) begin
            d = 7'($urandom_range(0, 127));
            p = good_parity_bit(d) ^ ($urandom_range(0, 3) == 0);
            tick($urandom_range(1, 50));
            send_frame(d, p, ~START_SIG, -1, t0);
            tick(8);
            expect_one("rand", t0, d, p, ~START_SIG);
            check("rand_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
